// File: rtl/bp_common_pkg.sv
// Shared CLINT definitions: device/register base offsets, register and FSM enums,
// and small helpers for access alignment and half-word store merging.
package bp_common_pkg;

    localparam logic [7:0]  clint_dev_gp           = 8'h02;
    localparam logic [23:0] clint_mipi_base_gp     = 24'h00_0000;
    localparam logic [23:0] clint_mtimecmp_base_gp = 24'h00_4000;
    localparam logic [23:0] clint_mtime_base_gp    = 24'h00_bff8;

    typedef enum logic [1:0] {
        e_mipi,
        e_mtimecmp,
        e_mtime,
        e_unmapped
    } bp_clint_reg_e;

    typedef enum logic {
        e_clint_idle,
        e_clint_resp
    } bp_clint_state_e;

    // Only 4B and 8B accesses exist, each naturally aligned.
    function automatic logic clint_aligned(input logic [1:0] size,
                                           input logic [2:0] off);
        case (size)
            2'd3:    return off == 3'b000;
            2'd2:    return off[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // A 4B store replaces only the addressed word of a 64b register.
    function automatic logic [63:0] clint_merge(input logic [63:0] old,
                                                input logic [63:0] wdata,
                                                input logic [1:0]  size,
                                                input logic        hi);
        if (size == 2'd3)
            return wdata;
        else if (hi)
            return {wdata[31:0], old[31:0]};
        else
            return {old[63:32], wdata[31:0]};
    endfunction

endpackage

// File: rtl/bp_clint_tick_sync.sv
// Brings an asynchronous RTC tick into clk_i: 2-flop synchronizer + rising edge.
// Ports: clk_i, reset_n_i, tick_i (async), tick_o (one-cycle pulse per rise).
module bp_clint_tick_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic tick_i,
    output logic tick_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            sync_q <= '0;
        else
            sync_q <= {sync_q[1:0], tick_i};
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bp_clint_responder.sv
// CLINT responder: MIPI / MTIMECMP / MTIME over a v/ready cmd, v/yumi resp link.
// Ports: cmd_* in, resp_* out, mtime_tick_i, soft_irq_o, timer_irq_o. BP_CLINT_TICK_SYNC_EN.
module bp_clint_responder
    import bp_common_pkg::*;
#(
    parameter int num_core_p   = 1,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_w_i,
    input  logic [addr_width_p-1:0] cmd_addr_i,
    input  logic [1:0]              cmd_size_i,
    input  logic [data_width_p-1:0] cmd_data_i,
    input  logic                    mtime_tick_i,
    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,
    output logic [data_width_p-1:0] resp_data_o,
    output logic                    resp_err_o,
    output logic [num_core_p-1:0]   soft_irq_o,
    output logic [num_core_p-1:0]   timer_irq_o
);

    bp_clint_state_e state_q;
    bp_clint_reg_e   reg_sel;

    logic                    ready_q, resp_v_q, resp_err_q;
    logic [data_width_p-1:0] resp_data_q;
    logic [63:0]             mtime_q;
    logic [63:0]             cmp_q [num_core_p];
    logic [num_core_p-1:0]   mipi_q, timer_q;

    logic [23:0] off;
    logic [31:0] off_w, idx;
    logic        hi, err, accept, wr, tick_en;
    logic [63:0] sel_val, rdata;

`ifdef BP_CLINT_TICK_SYNC_EN
    bp_clint_tick_sync u_tick_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_i    (mtime_tick_i),
        .tick_o    (tick_en)
    );
`else
    assign tick_en = mtime_tick_i;
`endif

    assign off    = cmd_addr_i[23:0];
    assign off_w  = {8'b0, off};
    assign hi     = off[2];
    assign accept = cmd_v_i & ready_q;
    assign wr     = accept & cmd_w_i & ~err;

    always_comb begin
        reg_sel = e_unmapped;
        idx     = '0;
        if (cmd_addr_i[31:24] == clint_dev_gp) begin
            if (off < clint_mtimecmp_base_gp) begin
                idx = (off_w - {8'b0, clint_mipi_base_gp}) >> 2;
                if (idx < num_core_p) reg_sel = e_mipi;
            end else if (off[23:3] == clint_mtime_base_gp[23:3]) begin
                reg_sel = e_mtime;
            end else if (off < clint_mtime_base_gp) begin
                idx = (off_w - {8'b0, clint_mtimecmp_base_gp}) >> 3;
                if (idx < num_core_p) reg_sel = e_mtimecmp;
            end
        end
    end

    assign err = (reg_sel == e_unmapped)
               | ~clint_aligned(cmd_size_i, off[2:0])
               | ((reg_sel == e_mipi) & (cmd_size_i != 2'd2));

    always_comb begin
        sel_val = '0;
        for (int c = 0; c < num_core_p; c++) begin
            if (idx == 32'(c)) begin
                if (reg_sel == e_mipi)     sel_val = {63'b0, mipi_q[c]};
                if (reg_sel == e_mtimecmp) sel_val = cmp_q[c];
            end
        end
        if (reg_sel == e_mtime) sel_val = mtime_q;
        rdata = '0;
        if (!err && !cmd_w_i) begin
            if (cmd_size_i == 2'd3)
                rdata = sel_val;
            else
                rdata = hi ? {32'b0, sel_val[63:32]} : {32'b0, sel_val[31:0]};
        end
    end

    // Register file; a store to mtime takes priority over a tick in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mtime_q <= '0;
            mipi_q  <= '0;
            timer_q <= '0;
            for (int c = 0; c < num_core_p; c++) cmp_q[c] <= '1;
        end else begin
            if (wr && reg_sel == e_mtime)
                mtime_q <= clint_merge(mtime_q, cmd_data_i, cmd_size_i, hi);
            else if (tick_en)
                mtime_q <= mtime_q + 64'd1;
            for (int c = 0; c < num_core_p; c++) begin
                if (wr && idx == 32'(c)) begin
                    if (reg_sel == e_mipi)
                        mipi_q[c] <= cmd_data_i[0];
                    if (reg_sel == e_mtimecmp)
                        cmp_q[c] <= clint_merge(cmp_q[c], cmd_data_i, cmd_size_i, hi);
                end
                timer_q[c] <= mtime_q >= cmp_q[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_clint_idle;
            ready_q     <= 1'b1;
            resp_v_q    <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            unique case (state_q)
                e_clint_idle: begin
                    if (accept) begin
                        state_q     <= e_clint_resp;
                        ready_q     <= 1'b0;
                        resp_v_q    <= 1'b1;
                        resp_err_q  <= err;
                        resp_data_q <= rdata;
                    end
                end
                e_clint_resp: begin
                    if (resp_yumi_i) begin
                        state_q     <= e_clint_idle;
                        ready_q     <= 1'b1;
                        resp_v_q    <= 1'b0;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= '0;
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign resp_v_o    = resp_v_q;
    assign resp_err_o  = resp_err_q;
    assign resp_data_o = resp_data_q;
    assign soft_irq_o  = mipi_q;
    assign timer_irq_o = timer_q;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed bench for bp_clint_responder with a response scoreboard.
// Default build: mtime_tick_i is a synchronous level enable.
module tb_bp_clint_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_v, cmd_ready, cmd_w, tick, resp_v, resp_yumi, resp_err;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [63:0] cmd_data, resp_data;
    logic [0:0]  soft_irq, timer_irq;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bp_clint_responder #(
        .num_core_p   (1),
        .addr_width_p (32),
        .data_width_p (64)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .cmd_v_i      (cmd_v),
        .cmd_ready_o  (cmd_ready),
        .cmd_w_i      (cmd_w),
        .cmd_addr_i   (cmd_addr),
        .cmd_size_i   (cmd_size),
        .cmd_data_i   (cmd_data),
        .mtime_tick_i (tick),
        .resp_v_o     (resp_v),
        .resp_yumi_i  (resp_yumi),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .soft_irq_o   (soft_irq),
        .timer_irq_o  (timer_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic get_resp(input string tag);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!resp_v && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_v"}, 64'(resp_v), 64'd1);
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected one entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, resp_data, e.data);
            chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
        end
        resp_yumi = 1'b1;
        @(posedge clk);
        #1 resp_yumi = 1'b0;
    endtask

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic [63:0] d,
                        input logic tk);
        int n = 0;
        @(negedge clk);
        cmd_v    = 1'b1;
        cmd_w    = w;
        cmd_addr = a;
        cmd_size = sz;
        cmd_data = d;
        tick     = tk;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic [63:0] d,
                          input logic [63:0] ed, input logic ee,
                          input logic tk = 1'b0);
        exp_q.push_back('{data: ed, err: ee});
        send(w, a, sz, d, tk);
        get_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_v = 1'b0; cmd_w = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_data = '0; tick = 1'b0; resp_yumi = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_resp_v", 64'(resp_v), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_soft", 64'(soft_irq), 64'd0);
        chk("rst_timer", 64'(timer_irq), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        do_cmd("rd_mtime0", 0, 32'h0200_bff8, 3, 0, 64'd0, 0);
        do_cmd("rd_cmp0", 0, 32'h0200_4000, 3, 0, '1, 0);
        do_cmd("rd_mipi0", 0, 32'h0200_0000, 2, 0, 64'd0, 0);

        do_cmd("wr_cmp10", 1, 32'h0200_4000, 3, 64'h10, 64'd0, 0);
        @(negedge clk);
        tick = 1'b1;
        repeat (16) @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
        chk("timer_at_0x10", 64'(timer_irq), 64'd0);
        @(negedge clk);
        chk("timer_rise", 64'(timer_irq), 64'd1);
        do_cmd("rd_mtime10", 0, 32'h0200_bff8, 3, 0, 64'h10, 0);

        do_cmd("wr_mipi1", 1, 32'h0200_0000, 2, 64'h1, 64'd0, 0);
        chk("soft_set", 64'(soft_irq), 64'd1);
        do_cmd("rd_mipi1", 0, 32'h0200_0000, 2, 0, 64'd1, 0);
        do_cmd("wr_mipi0", 1, 32'h0200_0000, 2, 64'h0, 64'd0, 0);
        chk("soft_clr", 64'(soft_irq), 64'd0);
        do_cmd("wr_mipi_fe", 1, 32'h0200_0000, 2, 64'hffff_fffe, 64'd0, 0);
        do_cmd("rd_mipi_fe", 0, 32'h0200_0000, 2, 0, 64'd0, 0);

        do_cmd("wr_mtime_max", 1, 32'h0200_bff8, 3, '1, 64'd0, 0);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        do_cmd("rd_mtime_wrap", 0, 32'h0200_bff8, 3, 0, 64'd0, 0);
        do_cmd("wr_mtime5_tick", 1, 32'h0200_bff8, 3, 64'd5, 64'd0, 0, 1'b1);
        do_cmd("rd_mtime5", 0, 32'h0200_bff8, 3, 0, 64'd5, 0);
        chk("timer_low", 64'(timer_irq), 64'd0);
        do_cmd("wr_mtime_hi", 1, 32'h0200_bffc, 2, 64'h1, 64'd0, 0);
        do_cmd("rd_mtime_hi", 0, 32'h0200_bff8, 3, 0, 64'h1_0000_0005, 0);
        chk("timer_hi", 64'(timer_irq), 64'd1);

        do_cmd("wr_cmp_ones", 1, 32'h0200_4000, 3, '1, 64'd0, 0);
        do_cmd("wr_cmp_hi", 1, 32'h0200_4004, 2, 64'hdead_beef, 64'd0, 0);
        do_cmd("rd_cmp8", 0, 32'h0200_4000, 3, 0, 64'hdead_beef_ffff_ffff, 0);
        do_cmd("rd_cmp_w1", 0, 32'h0200_4004, 2, 0, 64'hdead_beef, 0);
        do_cmd("rd_cmp_w0", 0, 32'h0200_4000, 2, 0, 64'hffff_ffff, 0);
        chk("timer_cleared", 64'(timer_irq), 64'd0);

        do_cmd("err_mipi_c1", 0, 32'h0200_0004, 2, 0, 64'd0, 1);
        do_cmd("err_misalign", 0, 32'h0200_4002, 3, 0, 64'd0, 1);
        do_cmd("err_unmapped", 0, 32'h0200_8000, 3, 0, 64'd0, 1);
        do_cmd("err_wr_cmp_c1", 1, 32'h0200_4008, 3, 64'h1234, 64'd0, 1);
        do_cmd("err_mipi_8b", 1, 32'h0200_0000, 3, 64'h1, 64'd0, 1);
        do_cmd("err_dev", 1, 32'h0300_0000, 2, 64'h1, 64'd0, 1);
        do_cmd("err_size1", 0, 32'h0200_bff8, 1, 0, 64'd0, 1);
        do_cmd("rd_cmp_kept", 0, 32'h0200_4000, 3, 0, 64'hdead_beef_ffff_ffff, 0);
        chk("soft_kept", 64'(soft_irq), 64'd0);

        exp_q.push_back('{data: 64'hdead_beef_ffff_ffff, err: 1'b0});
        send(0, 32'h0200_4000, 3, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_v", 64'(resp_v), 64'd1);
            chk("stall_data", resp_data, 64'hdead_beef_ffff_ffff);
            chk("stall_ready", 64'(cmd_ready), 64'd0);
        end
        get_resp("stall_rel");

        send(0, 32'h0200_bff8, 3, 0, 1'b0);
        @(negedge clk);
        chk("mid_v", 64'(resp_v), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(resp_v), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rel_v", 64'(resp_v), 64'd0);
        do_cmd("rd_mtime_rst", 0, 32'h0200_bff8, 3, 0, 64'd0, 0);
        do_cmd("rd_cmp_rst", 0, 32'h0200_4000, 3, 0, '1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_clint_responder.md
# bp_clint_responder

Memory-mapped responder for the core-local interruptor (CLINT) device window at 0x02xx_xxxx. It accepts single load/store commands from the uncached I/O path, services the MIPI, MTIMECMP and MTIME registers, and returns one response per command. It drives per-core machine software and timer interrupt lines into the BE.

## Interface
- num_core_p, 1: cores served; one MIPI and one MTIMECMP per core.
- addr_width_p, 32: command address width, low physical bits.
- data_width_p, 64: command/response data width.
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, reset asynchronous and active-low.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  responder can accept; v/ready handshake.
- cmd_w_i  in  1  1 = store, 0 = load.
- cmd_addr_i  in  addr_width_p  byte address.
- cmd_size_i  in  2  log2 bytes; only 2 (4B) and 3 (8B) legal.
- cmd_data_i  in  data_width_p  store data, LSB-aligned.
- mtime_tick_i  in  1  timebase increment request.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  consumer takes response; only while resp_v_o.
- resp_data_o  out  data_width_p  load data, LSB-aligned; 0 for stores/errors.
- resp_err_o  out  1  access fault.
- soft_irq_o  out  num_core_p  MIPI[c] bit 0.
- timer_irq_o  out  num_core_p  mtime >= mtimecmp[c].

## Operation
- FSM: IDLE -> RESP on cmd_v_i & cmd_ready_o; RESP -> IDLE on resp_yumi_i. cmd_ready_o = (state==IDLE); resp_v_o = (state==RESP).
- Decode (addr[31:24] must be 0x02, else err):
  - MIPI: 0x0200_0000 + 4c, c < num_core_p; 4B only; store writes bit 0, other bits read 0.
  - MTIMECMP: 0x0200_4000 + 8c; 8B at +0, or 4B at +0 (low) / +4 (high word).
  - MTIME: 0x0200_BFF8; same 8B/4B rules.
- Error (resp_err_o=1, no state change, data 0): unmapped offset, c >= num_core_p, size 0/1, 8B not 8-aligned, 4B not 4-aligned.
- 4B store writes only addressed half; other half unchanged.
- mtime: 64b, wraps 2^64-1 -> 0. Same-cycle store to mtime and tick: store wins, tick dropped.
- timer_irq_o[c] registered compare of post-update mtime vs mtimecmp[c], unsigned 64b.
- Reset: state IDLE, mtime 0, mtimecmp all ones, MIPI 0; all outputs 0 except cmd_ready_o=1 after reset released.

## Timing
- Register write at accept edge; response valid cycle after accept; load returns value before that write (no same-command hazard).
- resp_v_o/data/err held stable until resp_yumi_i; max throughput one command per 2 cycles.
- soft_irq_o changes cycle after MIPI store accept; timer_irq_o one cycle after the mtime/mtimecmp update.
- Reset asserted mid-transaction: response discarded, FSM IDLE immediately.

## Configuration
- BP_CLINT_TICK_SYNC_EN defined: mtime_tick_i treated as asynchronous RTC clock; 2-flop synchronizer plus rising-edge detect; mtime increments once per RTC rising edge, 3-cycle latency.
- Undefined: mtime_tick_i is synchronous level enable; mtime increments every cycle it is high, effective same edge.

## Structure
- Shared package bp_common_pkg: CLINT device base, MIPI/MTIMECMP/MTIME base-address constants, bp_clint_reg_e enum (e_mipi, e_mtimecmp, e_mtime, e_unmapped).
- One sub-module: bp_clint_tick_sync (synchronizer + edge detect, instantiated only under BP_CLINT_TICK_SYNC_EN).

## Test plan
- Reset, store 8B 0x0000_0000_0000_0010 to 0x0200_4000, tick 16 times -> timer_irq_o[0] rises one cycle after mtime reaches 0x10.
- Store 4B 0x1 to 0x0200_0000 -> resp_err_o=0, soft_irq_o[0]=1 next cycle; load returns 0x1; store 0x0 clears it.
- Store mtime 0xFFFF_FFFF_FFFF_FFFF, one tick -> mtime reads 0; store mtime 5 with simultaneous tick -> reads 5.
- 4B store 0xDEAD_BEEF to 0x0200_4004 -> 8B load 0x0200_4000 returns 0xDEAD_BEEF_FFFF_FFFF.
- Loads to 0x0200_0004 (num_core_p=1), 0x0200_4002 size 3, 0x0200_8000 -> resp_err_o=1, data 0, no register change.
- Hold resp_yumi_i low 10 cycles -> resp_v_o/data stable, cmd_ready_o low; assert reset_n_i low mid-RESP -> resp_v_o=0, cmd_ready_o=1 after release.
